// File: rtl/bsu_pkg.sv
// Shared definitions for the BSU channel-load sequencer: state encoding,
// decoder select codes and small combinational helpers.
package bsu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_DONE   = 3'd4
  } bsu_state_e;

  localparam logic [4:0] SEL_IDLE = 5'd0;
  localparam logic [4:0] SEL_CH0  = 5'd6;
  localparam logic [4:0] SEL_CH1  = 5'd10;
  localparam logic [4:0] SEL_CH2  = 5'd14;
  localparam logic [4:0] SEL_CH3  = 5'd18;

  // Decoder select code for a channel index.
  function automatic logic [4:0] sel_code(input logic [1:0] ch);
    logic [4:0] code;
    case (ch)
      2'd0:    code = SEL_CH0;
      2'd1:    code = SEL_CH1;
      2'd2:    code = SEL_CH2;
      2'd3:    code = SEL_CH3;
      default: code = SEL_IDLE;
    endcase
    return code;
  endfunction

  // Lowest set mask bit at or above 'from'; result is {found, index}.
  function automatic logic [2:0] first_set(input logic [3:0] mask, input logic [2:0] from);
    logic [2:0] res;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i] && (3'(i) >= from)) begin
        res = {1'b1, 2'(i)};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Counter width able to hold (longest phase - 1), never less than one bit.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/bsu_phase_timer.sv
// Single down-counter shared by the SETUP/STROBE/HOLD phases. Loading N-1
// on phase entry makes 'expire' rise in the N-th cycle of that phase.
module bsu_phase_timer #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expire
);

  logic [CNT_W-1:0] cnt_r;

  // Load on phase entry, otherwise count down and park at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (cnt_r != {CNT_W{1'b0}}) begin
      cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expire = (cnt_r == {CNT_W{1'b0}});

endmodule

// File: rtl/bsu_load_seq.sv
// Sequencer that loads up to four phase words into a channel decoder:
// per masked channel it presents sel/data (SETUP), pulses en (STROBE) and
// holds sel/data (HOLD). All outputs are registered from the next state so
// they line up with the state register.
module bsu_load_seq
  import bsu_pkg::*;
#(
  parameter int PHASE_W    = 6,
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 4,
  parameter int HOLD_CYC   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [4*PHASE_W-1:0] cmd_phase,
  input  logic [3:0]           cmd_mask,
  input  logic                 abort,
  output logic                 dec_en,
  output logic [4:0]           dec_sel,
  output logic [PHASE_W-1:0]   ps_data,
  output logic [1:0]           ch_idx,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted
);

  localparam int CNT_W = cnt_width(SETUP_CYC, STROBE_CYC, HOLD_CYC);
  localparam logic [CNT_W-1:0] LD_SETUP  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] LD_STROBE = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] LD_HOLD   = CNT_W'(HOLD_CYC - 1);

  bsu_state_e           state_r, state_nxt_s;
  logic [1:0]           ch_r, ch_nxt_s;
  logic [4*PHASE_W-1:0] phase_r, data_src_s;
  logic [3:0]           mask_r;
  logic [PHASE_W-1:0]   word_s;
  logic [2:0]           next_s;
  logic [CNT_W-1:0]     load_val_s;
  logic                 load_s, expire_s, capture_s, abort_hit_s, active_s;

  bsu_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load_s),
    .load_val (load_val_s),
    .expire   (expire_s)
  );

  // Next-state logic; abort wins over a phase expiry in the same cycle.
  always_comb begin
    state_nxt_s = state_r;
    ch_nxt_s    = ch_r;
    load_s      = 1'b0;
    load_val_s  = {CNT_W{1'b0}};
    capture_s   = 1'b0;
    abort_hit_s = 1'b0;
    next_s      = 3'b000;
    case (state_r)
      ST_IDLE: begin
        if (cmd_valid) begin
          capture_s = 1'b1;
          next_s    = first_set(cmd_mask, 3'd0);
          if (next_s[2]) begin
            state_nxt_s = ST_SETUP;
            ch_nxt_s    = next_s[1:0];
            load_s      = 1'b1;
            load_val_s  = LD_SETUP;
          end else begin
            state_nxt_s = ST_DONE;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (abort) begin
          state_nxt_s = ST_IDLE;
          abort_hit_s = 1'b1;
        end else if (expire_s) begin
          state_nxt_s = ST_STROBE;
          load_s      = 1'b1;
          load_val_s  = LD_STROBE;
        end else begin
          state_nxt_s = ST_SETUP;
        end
      end
      ST_STROBE: begin
        if (abort) begin
          state_nxt_s = ST_IDLE;
          abort_hit_s = 1'b1;
        end else if (expire_s) begin
          state_nxt_s = ST_HOLD;
          load_s      = 1'b1;
          load_val_s  = LD_HOLD;
        end else begin
          state_nxt_s = ST_STROBE;
        end
      end
      ST_HOLD: begin
        if (abort) begin
          state_nxt_s = ST_IDLE;
          abort_hit_s = 1'b1;
        end else if (expire_s) begin
          next_s = first_set(mask_r, {1'b0, ch_r} + 3'd1);
          if (next_s[2]) begin
            state_nxt_s = ST_SETUP;
            ch_nxt_s    = next_s[1:0];
            load_s      = 1'b1;
            load_val_s  = LD_SETUP;
          end else begin
            state_nxt_s = ST_DONE;
          end
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Phase word for the next channel; on acceptance take it straight from the port.
  always_comb begin
    data_src_s = capture_s ? cmd_phase : phase_r;
    active_s   = (state_nxt_s == ST_SETUP) || (state_nxt_s == ST_STROBE) ||
                 (state_nxt_s == ST_HOLD);
    case (ch_nxt_s)
      2'd0:    word_s = data_src_s[0*PHASE_W +: PHASE_W];
      2'd1:    word_s = data_src_s[1*PHASE_W +: PHASE_W];
      2'd2:    word_s = data_src_s[2*PHASE_W +: PHASE_W];
      2'd3:    word_s = data_src_s[3*PHASE_W +: PHASE_W];
      default: word_s = {PHASE_W{1'b0}};
    endcase
  end

  // State, channel pointer and captured command.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      ch_r    <= 2'd0;
      phase_r <= {(4*PHASE_W){1'b0}};
      mask_r  <= 4'd0;
    end else begin
      state_r <= state_nxt_s;
      ch_r    <= ch_nxt_s;
      phase_r <= capture_s ? cmd_phase : phase_r;
      mask_r  <= capture_s ? cmd_mask : mask_r;
    end
  end

  // Registered outputs derived from the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      dec_en    <= 1'b0;
      dec_sel   <= SEL_IDLE;
      ps_data   <= {PHASE_W{1'b0}};
      ch_idx    <= 2'd0;
    end else begin
      cmd_ready <= (state_nxt_s == ST_IDLE);
      busy      <= (state_nxt_s != ST_IDLE);
      done      <= (state_nxt_s == ST_DONE);
      aborted   <= abort_hit_s;
      dec_en    <= (state_nxt_s == ST_STROBE);
      dec_sel   <= active_s ? sel_code(ch_nxt_s) : SEL_IDLE;
      ps_data   <= active_s ? word_s : {PHASE_W{1'b0}};
      ch_idx    <= active_s ? ch_nxt_s : 2'd0;
    end
  end

endmodule
